// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the asynchronous FIFO pointers:
//                Gray/binary conversion and the full-test MSB inversion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package fifo_pkg;

    // Default RAM address width (FIFO depth 2**ADDR_W).
    localparam int unsigned ADDR_W_DEF = 4;

    // The helpers work on a fixed-width carrier. Callers zero-extend into it
    // and truncate the result back to their pointer width.
    localparam int unsigned FN_W = 32;
    typedef logic [FN_W-1:0] vec_t;

    // Binary to Gray. Bits at and above 'width' are forced to zero.
    function automatic vec_t bin2gray(input vec_t bin, input int unsigned width);
        vec_t mask;
        mask = (width >= FN_W) ? '1 : ((vec_t'(1) << width) - vec_t'(1));
        return (bin ^ (bin >> 1)) & mask;
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits above it.
    function automatic vec_t gray2bin(input vec_t gray, input int unsigned width);
        vec_t mask;
        vec_t bin;
        mask = (width >= FN_W) ? '1 : ((vec_t'(1) << width) - vec_t'(1));
        bin  = gray & mask;
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i] ^ bin[i+1];
        end
        return bin;
    endfunction

    // Gray pointer that the write pointer equals when the FIFO is exactly
    // one lap ahead of the read pointer: invert the two MSBs of the
    // (addr_w+1)-bit Gray read pointer.
    function automatic vec_t full_ptr(input vec_t rq_gray, input int unsigned addr_w);
        return rq_gray ^ (vec_t'(3) << (addr_w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_ctrl_if.sv
// ============================================================================
//  Module      : fifo_wr_ctrl_if
//  Description : Write-side bus of the asynchronous FIFO: write request,
//                synchronized read pointer in; RAM strobe/address, Gray write
//                pointer and status flags out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              wr_en;
    logic [ADDR_W:0]   rq2_wptr;
    logic [ADDR_W-1:0] waddr;
    logic              wr_we;
    logic [ADDR_W:0]   wptr;
    logic              wfull;
    logic              wafull;
    logic              wovf;

    // Producer / environment side.
    modport master (
        output wr_en,
        output rq2_wptr,
        input  waddr,
        input  wr_we,
        input  wptr,
        input  wfull,
        input  wafull,
        input  wovf
    );

    // Write-pointer controller side.
    modport slave (
        input  wr_en,
        input  rq2_wptr,
        output waddr,
        output wr_we,
        output wptr,
        output wfull,
        output wafull,
        output wovf
    );

endinterface

`default_nettype wire

// File: rtl/gray2bin_conv.sv
// ============================================================================
//  Module      : gray2bin_conv
//  Description : Combinational Gray-to-binary converter (XOR prefix from the
//                MSB downwards).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int unsigned W = ADDR_W_DEF + 1
) (
    input  wire logic [W-1:0] i_gray,
    output logic      [W-1:0] o_bin
);

    // Binary bit i is the XOR of Gray bits W-1 down to i.
    for (genvar i = 0; i < W; i++) begin : g_chain
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
// ============================================================================
//  Module      : fifo_wr_ctrl
//  Description : Write-domain pointer and flag controller of the asynchronous
//                FIFO. Keeps binary/Gray write pointers, drives the RAM write
//                strobe/address and derives full, almost-full and a sticky
//                overflow flag from the synchronized Gray read pointer.
//  Config      : define FIFO_WR_AFULL_EN to build the almost-full flag;
//                otherwise wafull is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned AFULL_TH = (2**ADDR_W) - 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fifo_wr_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    // Reject configurations the pointer arithmetic cannot represent.
    if (ADDR_W < 2 || AFULL_TH > (2**ADDR_W)) begin : g_param_check
        $error("fifo_wr_ctrl: ADDR_W must be >= 2 and AFULL_TH <= 2**ADDR_W");
    end

    logic [ADDR_W:0] r_wbin;
    logic [ADDR_W:0] r_wptr;
    logic            r_wfull;
    logic            r_wovf;

    logic            w_wr_we;
    logic [ADDR_W:0] w_wbin_next;
    logic [ADDR_W:0] w_wgray_next;
    logic [ADDR_W:0] w_full_ptr;
    logic            w_full_next;

    // A write is accepted only while not full; the RAM captures on the same
    // edge that advances the pointer.
    assign w_wr_we      = bus.wr_en & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_wr_we};
    assign w_wgray_next = PTR_W'(bin2gray(vec_t'(w_wbin_next), PTR_W));

    // Full when the next write pointer is one full lap ahead of the read
    // pointer. The read pointer lags by the synchronizer, so this can only
    // err towards reporting full too long, never too short.
    assign w_full_ptr   = PTR_W'(full_ptr(vec_t'(bus.rq2_wptr), ADDR_W));
    assign w_full_next  = (w_wgray_next == w_full_ptr);

    // Pointer, full and overflow registers; overflow is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
            r_wovf  <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wptr  <= w_wgray_next;
            r_wfull <= w_full_next;
            r_wovf  <= r_wovf | (bus.wr_en & r_wfull);
        end
    end

`ifdef FIFO_WR_AFULL_EN
    localparam logic [ADDR_W:0] c_afull_th = PTR_W'(AFULL_TH);

    logic [ADDR_W:0] w_rbin;
    logic [ADDR_W:0] w_fill_next;
    logic            w_afull_next;
    logic            r_wafull;

    gray2bin_conv #(
        .W      (PTR_W)
    ) u_rq2_conv (
        .i_gray (bus.rq2_wptr),
        .o_bin  (w_rbin)
    );

    // Occupancy after this cycle's write; modular subtraction handles the
    // lap wrap of either pointer.
    assign w_fill_next  = w_wbin_next - w_rbin;
    assign w_afull_next = (w_fill_next >= c_afull_th);

    // Almost-full register, same timing as the full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wafull <= 1'b0;
        end else begin
            r_wafull <= w_afull_next;
        end
    end

    assign bus.wafull = r_wafull;
`else
    assign bus.wafull = 1'b0;
`endif

    assign bus.wr_we = w_wr_we;
    assign bus.waddr = r_wbin[ADDR_W-1:0];
    assign bus.wptr  = r_wptr;
    assign bus.wfull = r_wfull;
    assign bus.wovf  = r_wovf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
// ============================================================================
//  Module      : tb_fifo_wr_ctrl
//  Description : Self-checking bench for fifo_wr_ctrl (ADDR_W=4, AFULL_TH=14)
//                against an occupancy-count model of the write side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_wr_ctrl;

    localparam int AW = 4;

`ifdef FIFO_WR_AFULL_EN
    localparam bit AFULL_ON = 1'b1;
`else
    localparam bit AFULL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fifo_wr_ctrl_if #(.ADDR_W(AW)) bus ();

    fifo_wr_ctrl #(
        .ADDR_W   (AW),
        .AFULL_TH (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: total writes accepted and reads seen, plus the flags they imply.
    int         m_wcnt;
    int         m_rcnt;
    bit         m_full;
    bit         m_afull;
    bit         m_ovf;
    // Combinational outputs sampled in the last cycle, and their expectations.
    logic       o_we;
    logic [3:0] o_waddr;
    bit         e_we;
    logic [3:0] e_waddr;

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wcnt  = 0;
        m_rcnt  = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock: drive request and read count, sample strobe/address mid-cycle,
    // advance the model, return 1 ns after the edge.
    task automatic cycle(input bit we, input int rc);
        int fill;
        bus.wr_en    = we;
        bus.rq2_wptr = gray5(rc);
        m_rcnt       = rc;
        @(negedge clk);
        o_we    = bus.wr_we;
        o_waddr = bus.waddr;
        e_we    = we && !m_full;
        e_waddr = 4'(m_wcnt % 16);
        if (we && m_full)  m_ovf = 1'b1;
        if (we && !m_full) m_wcnt++;
        fill    = (m_wcnt - m_rcnt) % 32;
        m_full  = (fill == 16);
        m_afull = AFULL_ON && (fill >= 14);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.wr_en  = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rq2_wptr = '0;
        model_reset();
        #2;
        checks++; if (bus.wptr !== 5'd0) begin errors++; $display("FAIL reset_init_wptr: got %b want 00000", bus.wptr); end
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL reset_init_wfull: got %b want 0", bus.wfull); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Run to full and overflow so every register holds a non-reset value.
        repeat (17) cycle(1'b1, 0);
        checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL reset_pre_wovf: got %b want 1", bus.wovf); end
        #2;
        rst_n     = 1'b0;
        bus.wr_en = 1'b1;
        #1;
        checks++; if (bus.wptr !== 5'd0) begin errors++; $display("FAIL reset_async_wptr: got %b want 00000", bus.wptr); end
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL reset_async_waddr: got %0d want 0", bus.waddr); end
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL reset_async_wfull: got %b want 0", bus.wfull); end
        checks++; if (bus.wafull !== 1'b0) begin errors++; $display("FAIL reset_async_wafull: got %b want 0", bus.wafull); end
        checks++; if (bus.wovf !== 1'b0) begin errors++; $display("FAIL reset_async_wovf: got %b want 0", bus.wovf); end
        checks++; if (bus.wr_we !== 1'b1) begin errors++; $display("FAIL reset_wr_we_follows: got %b want 1", bus.wr_we); end
        bus.wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 0);
            checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL fill_wr_we[%0d]: got %b want 1", k, o_we); end
            checks++; if (o_waddr !== 4'(k - 1)) begin errors++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", k, o_waddr, k - 1); end
            checks++; if (bus.wptr !== gray5(k)) begin errors++; $display("FAIL fill_wptr[%0d]: got %b want %b", k, bus.wptr, gray5(k)); end
            checks++; if (bus.wfull !== (k == 16)) begin errors++; $display("FAIL fill_wfull[%0d]: got %b want %b", k, bus.wfull, (k == 16)); end
            checks++; if (bus.wafull !== (AFULL_ON && k >= 14)) begin errors++; $display("FAIL fill_wafull[%0d]: got %b want %b", k, bus.wafull, (AFULL_ON && k >= 14)); end
        end
        checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL fill_final_wptr: got %b want 11000", bus.wptr); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 0);
            checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL ovf_wr_we[%0d]: got %b want 0", k, o_we); end
            checks++; if (o_waddr !== 4'd0) begin errors++; $display("FAIL ovf_waddr[%0d]: got %0d want 0", k, o_waddr); end
            checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr[%0d]: got %b want 11000", k, bus.wptr); end
            checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_wovf[%0d]: got %b want 1", k, bus.wovf); end
        end
        cycle(1'b0, 0);
        checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.wovf); end
        checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %b want 1", bus.wfull); end
    endtask

    task automatic test_drain_release();
        cycle(1'b0, 1);
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL drain_wfull: got %b want 0", bus.wfull); end
        checks++; if (bus.wafull !== AFULL_ON) begin errors++; $display("FAIL drain_wafull: got %b want %b", bus.wafull, AFULL_ON); end
        checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL drain_wptr: got %b want 11000", bus.wptr); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            // Read pointer trails the write pointer by two cycles.
            cycle(1'b1, (k >= 2) ? (k - 2) : 0);
            checks++; if (o_waddr !== 4'(k % 16)) begin errors++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", k, o_waddr, k % 16); end
            checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL wrap_wr_we[%0d]: got %b want 1", k, o_we); end
            checks++; if (bus.wptr !== gray5(k + 1)) begin errors++; $display("FAIL wrap_wptr[%0d]: got %b want %b", k, bus.wptr, gray5(k + 1)); end
            checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL wrap_wfull[%0d]: got %b want 0", k, bus.wfull); end
            checks++; if (bus.wafull !== 1'b0) begin errors++; $display("FAIL wrap_wafull[%0d]: got %b want 0", k, bus.wafull); end
        end
    endtask

    task automatic test_random();
        int rc;
        bit we;
        do_reset();
        rc = 0;
        for (int k = 0; k < 600; k++) begin
            // Phase 1 mostly writes (reaches full/overflow), phase 2 mostly drains.
            if (k < 300) begin
                we = ($urandom_range(0, 3) != 0);
                if (rc < m_wcnt && $urandom_range(0, 3) == 0) rc++;
            end else begin
                we = ($urandom_range(0, 2) == 0);
                if (rc < m_wcnt && $urandom_range(0, 1) == 0) rc++;
            end
            cycle(we, rc);
            checks++; if (o_we !== e_we) begin errors++; $display("FAIL rand_wr_we[%0d]: got %b want %b", k, o_we, e_we); end
            checks++; if (o_waddr !== e_waddr) begin errors++; $display("FAIL rand_waddr[%0d]: got %0d want %0d", k, o_waddr, e_waddr); end
            checks++; if (bus.wptr !== gray5(m_wcnt)) begin errors++; $display("FAIL rand_wptr[%0d]: got %b want %b", k, bus.wptr, gray5(m_wcnt)); end
            checks++; if (bus.wfull !== m_full) begin errors++; $display("FAIL rand_wfull[%0d]: got %b want %b", k, bus.wfull, m_full); end
            checks++; if (bus.wafull !== m_afull) begin errors++; $display("FAIL rand_wafull[%0d]: got %b want %b", k, bus.wafull, m_afull); end
            checks++; if (bus.wovf !== m_ovf) begin errors++; $display("FAIL rand_wovf[%0d]: got %b want %b", k, bus.wovf, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
